fp_round: RTL and testbench



---
 rtl/fp_round.sv | 201 ++++++++++++++++++++
 tb/tb_fp_round.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_round.sv
// fp_round: pipelined IEEE-754 round-to-integral with per-operand mode (nearest-even/trunc/floor/ceil).
// Latency 3 cycles (S1 classify, S2 mask + increment decision, S3 increment/carry/repack), 1 result/cycle.
// Backpressure: one global enable stalls all stages; in_ready = !out_valid || out_ready, no skid buffer.
// Optional flag outputs (out_inexact, out_invalid) are built only when FP_ROUND_FLAGS_EN is defined.
module fp_round #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [1:0]           in_mode,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [EXP_W+MAN_W:0] out_z,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef FP_ROUND_FLAGS_EN
  ,
  output logic                 out_inexact,
  output logic                 out_invalid
`endif
);

  localparam int KW   = $clog2(MAN_W + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [1:0] M_NE = 2'b00;
  localparam logic [1:0] M_TR = 2'b01;
  localparam logic [1:0] M_FL = 2'b10;
  localparam logic [1:0] M_CE = 2'b11;
  localparam logic [MAN_W-1:0] ONE_F  = {{(MAN_W-1){1'b0}}, 1'b1};
  localparam logic [MAN_W:0]   ONE_M  = {{MAN_W{1'b0}}, 1'b1};
  localparam logic [MAN_W-1:0] QUIET  = {1'b1, {(MAN_W-1){1'b0}}};

  // C_PASS: inf, zero, already integral. C_SMALL: nonzero |x| < 1. C_FRAC: 0 <= e < MAN_W.
  typedef enum logic [1:0] {C_PASS, C_NAN, C_SMALL, C_FRAC} cls_e;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: unpack / classify ----------------
  logic             a_sign;
  logic [EXP_W-1:0] a_exp;
  logic [MAN_W-1:0] a_frac;
  logic [31:0]      a_exp32;
  assign {a_sign, a_exp, a_frac} = in_a;
  assign a_exp32 = 32'(a_exp);

  cls_e             s1_cls_d, s1_cls_q;
  logic [KW-1:0]    s1_k_d, s1_k_q;
  logic             v1_q, s1_sign_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [MAN_W-1:0] s1_frac_q;
  logic [1:0]       s1_mode_q;

  // Classify the operand; k is the number of fraction bits below the binary point.
  always_comb begin
    s1_cls_d = C_FRAC;
    s1_k_d   = KW'(32'(BIAS + MAN_W) - a_exp32);
    if (a_exp == '1)                          s1_cls_d = (a_frac == '0) ? C_PASS : C_NAN;
    else if (a_exp == '0 && a_frac == '0)     s1_cls_d = C_PASS;
    else if (a_exp32 < 32'(BIAS))             s1_cls_d = C_SMALL;
    else if (a_exp32 >= 32'(BIAS + MAN_W))    s1_cls_d = C_PASS;
  end

  // S1 register; reset drops any operand in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
    end else if (en) begin
      v1_q      <= in_valid;
      s1_sign_q <= a_sign;
      s1_exp_q  <= a_exp;
      s1_frac_q <= a_frac;
      s1_mode_q <= in_mode;
      s1_cls_q  <= s1_cls_d;
      s1_k_q    <= s1_k_d;
    end
  end

  // ---------------- S2: mask and increment decision ----------------
  logic [MAN_W-1:0] mask2, half2, rem2;
  logic             kept_lsb2, inc2, one2;
  logic [EXP_W-1:0] s2_exp_d, s2_exp_q;
  logic [MAN_W-1:0] s2_frac_d, s2_frac_q;
  logic [MAN_W:0]   s2_incv_d, s2_incv_q;
  logic             v2_q, s2_sign_q;

  // Clear the discarded bits and decide whether to add one unit in the last kept place.
  always_comb begin
    mask2     = (ONE_F << s1_k_q) - ONE_F;
    half2     = ONE_F << (s1_k_q - KW'(1));
    rem2      = s1_frac_q & mask2;
    // Hidden bit included so that k == MAN_W sees the integer bit as the kept LSB.
    kept_lsb2 = |({1'b1, s1_frac_q} & (ONE_M << s1_k_q));
    inc2      = 1'b0;
    one2      = 1'b0;
    case (s1_mode_q)
      M_NE:    inc2 = (rem2 > half2) || ((rem2 == half2) && kept_lsb2);
      M_FL:    inc2 = s1_sign_q && (rem2 != '0);
      M_CE:    inc2 = !s1_sign_q && (rem2 != '0);
      default: inc2 = 1'b0;
    endcase
    case (s1_mode_q)
      M_NE:    one2 = (s1_exp_q == EXP_W'(BIAS - 1)) && (s1_frac_q != '0);
      M_FL:    one2 = s1_sign_q;
      M_CE:    one2 = !s1_sign_q;
      default: one2 = 1'b0;
    endcase
    s2_exp_d  = s1_exp_q;
    s2_frac_d = s1_frac_q;
    s2_incv_d = '0;
    case (s1_cls_q)
      C_NAN:   s2_frac_d = s1_frac_q | QUIET;
      C_SMALL: begin
        s2_exp_d  = one2 ? EXP_W'(BIAS) : '0;
        s2_frac_d = '0;
      end
      C_FRAC:  begin
        s2_frac_d = s1_frac_q & ~mask2;
        s2_incv_d = inc2 ? (ONE_M << s1_k_q) : '0;
      end
      default: ;
    endcase
  end

  // S2 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q <= 1'b0;
    end else if (en) begin
      v2_q      <= v1_q;
      s2_sign_q <= s1_sign_q;
      s2_exp_q  <= s2_exp_d;
      s2_frac_q <= s2_frac_d;
      s2_incv_q <= s2_incv_d;
    end
  end

  // ---------------- S3: increment, carry, repack ----------------
  logic [MAN_W:0]         sum3;
  logic [EXP_W-1:0]       exp3;
  logic                   v3_q;
  logic [EXP_W+MAN_W:0]   z_q;

  // A carry out of the fraction leaves it all-zero and bumps the exponent; e < MAN_W keeps it finite.
  always_comb begin
    sum3 = {1'b0, s2_frac_q} + s2_incv_q;
    exp3 = s2_exp_q + EXP_W'(sum3[MAN_W]);
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      v3_q <= 1'b0;
      z_q  <= '0;
    end else if (en) begin
      v3_q <= v2_q;
      z_q  <= {s2_sign_q, exp3, sum3[MAN_W-1:0]};
    end
  end

  assign out_z     = z_q;
  assign out_valid = v3_q;

`ifdef FP_ROUND_FLAGS_EN
  logic s2_inex_d, s2_inv_d, s2_inex_q, s2_inv_q, inex3_q, inv3_q;

  // Inexact whenever nonzero bits are dropped; invalid only for signalling NaNs.
  always_comb begin
    s2_inex_d = 1'b0;
    s2_inv_d  = 1'b0;
    case (s1_cls_q)
      C_SMALL: s2_inex_d = 1'b1;
      C_FRAC:  s2_inex_d = (rem2 != '0);
      C_NAN:   s2_inv_d  = !s1_frac_q[MAN_W-1];
      default: ;
    endcase
  end

  // Flag pipeline, kept in step with the data stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_inex_q <= 1'b0;
      s2_inv_q  <= 1'b0;
      inex3_q   <= 1'b0;
      inv3_q    <= 1'b0;
    end else if (en) begin
      s2_inex_q <= s2_inex_d;
      s2_inv_q  <= s2_inv_d;
      inex3_q   <= s2_inex_q;
      inv3_q    <= s2_inv_q;
    end
  end

  assign out_inexact = inex3_q;
  assign out_invalid = inv3_q;
`endif

endmodule

// File: tb/tb_fp_round.sv
// tb_fp_round: scoreboard bench for fp_round (default, double and half parameterisations).
// Expected results are pushed when an operand is accepted and popped when the DUT hands one off.
// Build with FP_ROUND_FLAGS_EN defined to also check out_inexact / out_invalid.
module tb_fp_round;

  localparam logic [1:0] NE = 2'b00, TR = 2'b01, FL = 2'b10, CE = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] in_a, out_z;
  logic [1:0]  in_mode;
  logic        in_valid, in_ready, out_valid, out_ready;

  logic [63:0] d_a, d_z;
  logic [1:0]  d_mode;
  logic        d_valid, d_rdy, d_ovalid;
  logic [15:0] h_a, h_z;
  logic [1:0]  h_mode;
  logic        h_valid, h_rdy, h_ovalid;
  logic        tie_rdy;
  assign tie_rdy = 1'b1;

`ifdef FP_ROUND_FLAGS_EN
  logic out_inexact, out_invalid, d_inex, d_inv, h_inex, h_inv;
`endif

  fp_round dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready),
    .out_z(out_z), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FP_ROUND_FLAGS_EN
    , .out_inexact(out_inexact), .out_invalid(out_invalid)
`endif
  );

  fp_round #(.EXP_W(11), .MAN_W(52)) dut_d (
    .clk(clk), .rst(rst), .in_a(d_a), .in_mode(d_mode), .in_valid(d_valid), .in_ready(d_rdy),
    .out_z(d_z), .out_valid(d_ovalid), .out_ready(tie_rdy)
`ifdef FP_ROUND_FLAGS_EN
    , .out_inexact(d_inex), .out_invalid(d_inv)
`endif
  );

  fp_round #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .in_a(h_a), .in_mode(h_mode), .in_valid(h_valid), .in_ready(h_rdy),
    .out_z(h_z), .out_valid(h_ovalid), .out_ready(tie_rdy)
`ifdef FP_ROUND_FLAGS_EN
    , .out_inexact(h_inex), .out_invalid(h_inv)
`endif
  );

  typedef struct {
    logic [31:0] a;
    logic [1:0]  m;
    logic [31:0] z;
    int          acc;
    bit          lat;
    bit          inex;
    bit          inv;
  } sb_t;

  sb_t         sb[$];
  int          checks = 0, errors = 0, cyc = 0, n_out = 0;
  bit          acc_flag, lat_chk;
  logic [31:0] pend_z;
  logic        smp_in_ready, smp_out_valid, smp_d_vld, smp_h_vld, smp_d_rdy, smp_h_rdy;
  logic [31:0] smp_out_z;
  logic [63:0] smp_d_z;
  logic [15:0] smp_h_z;
  logic        smp_d_inex, smp_h_inex;

  // One clock cycle: sample at negedge, score any output handshake, record any accept, advance.
  task automatic step();
    sb_t e;
    bit  nan;
    @(negedge clk);
    smp_in_ready = in_ready; smp_out_valid = out_valid; smp_out_z = out_z;
    smp_d_vld = d_ovalid; smp_d_z = d_z; smp_h_vld = h_ovalid; smp_h_z = h_z;
    smp_d_rdy = d_rdy; smp_h_rdy = h_rdy;
`ifdef FP_ROUND_FLAGS_EN
    smp_d_inex = d_inex; smp_h_inex = h_inex;
`else
    smp_d_inex = 1'b0; smp_h_inex = 1'b0;
`endif
    acc_flag = 1'b0;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got %h required no result", out_z);
      end else begin
        e = sb.pop_front();
        if (out_z !== e.z) begin
          errors++;
          $display("FAIL result a=%h mode=%0d got %h required %h", e.a, e.m, out_z, e.z);
        end
        if (e.lat) begin
          checks++;
          if (cyc - e.acc != 3) begin
            errors++;
            $display("FAIL latency a=%h got %0d cycles required 3", e.a, cyc - e.acc);
          end
        end
`ifdef FP_ROUND_FLAGS_EN
        checks++;
        if (out_inexact !== e.inex || out_invalid !== e.inv) begin
          errors++;
          $display("FAIL flags a=%h mode=%0d got inexact=%b invalid=%b required %b %b",
                   e.a, e.m, out_inexact, out_invalid, e.inex, e.inv);
        end
`endif
      end
    end
    if (!rst && in_valid && in_ready) begin
      nan    = (in_a[30:23] == 8'hFF) && (in_a[22:0] != 23'd0);
      e.a    = in_a;
      e.m    = in_mode;
      e.z    = pend_z;
      e.acc  = cyc;
      e.lat  = lat_chk;
      e.inex = !nan && (pend_z != in_a);
      e.inv  = nan && !in_a[22];
      sb.push_back(e);
      acc_flag = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [31:0] a, input logic [1:0] m, input logic [31:0] z);
    int n;
    in_a = a; in_mode = m; pend_z = z; in_valid = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!acc_flag && n < 40);
    if (!acc_flag) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout a=%h in_ready held low, required accept within 40 cycles", a);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      step();
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain %0d results outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_mode = NE; out_ready = 1'b1; pend_z = '0;
    d_valid = 1'b0; d_a = '0; d_mode = NE; h_valid = 1'b0; h_a = '0; h_mode = NE; lat_chk = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    checks++;
    if (smp_out_valid !== 1'b0 || smp_out_z !== 32'h0) begin
      errors++;
      $display("FAIL reset_out got valid=%b z=%h required 0 00000000", smp_out_valid, smp_out_z);
    end
    checks++;
    if (smp_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 1", smp_in_ready);
    end
    checks++;
    if (smp_d_vld !== 1'b0 || smp_h_vld !== 1'b0 || smp_d_z !== 64'h0 || smp_h_z !== 16'h0) begin
      errors++;
      $display("FAIL reset_params got d_valid=%b h_valid=%b required 0 0", smp_d_vld, smp_h_vld);
    end
  endtask

  task automatic test_basic();
    lat_chk = 1'b1;
    send(32'h3FC00000, CE, 32'h40000000);
    send(32'hBFC00000, FL, 32'hC0000000);
    send(32'hBF333333, TR, 32'h80000000);
    send(32'h3E99999A, CE, 32'h3F800000);
    drain();
  endtask

  task automatic test_ties_carry();
    send(32'h40200000, NE, 32'h40000000);
    send(32'h40600000, NE, 32'h40800000);
    send(32'h3F000000, NE, 32'h00000000);
    send(32'h4AFFFFFF, CE, 32'h4B000000);
    send(32'hBFC00000, NE, 32'hC0000000);
    send(32'h3FC00001, NE, 32'h40000000);
    send(32'h3EFFFFFF, NE, 32'h00000000);
    send(32'hBF000001, NE, 32'hBF800000);
    drain();
  endtask

  task automatic test_specials();
    send(32'h7F800000, NE, 32'h7F800000);
    send(32'h7F800000, TR, 32'h7F800000);
    send(32'h7F800000, FL, 32'h7F800000);
    send(32'hFF800000, CE, 32'hFF800000);
    send(32'h7FA00000, NE, 32'h7FE00000);
    send(32'h7FC00000, FL, 32'h7FC00000);
    send(32'h80000000, FL, 32'h80000000);
    send(32'h4B800001, NE, 32'h4B800001);
    send(32'h00000001, CE, 32'h3F800000);
    send(32'h00000001, FL, 32'h00000000);
    send(32'h80000001, FL, 32'hBF800000);
    drain();
  endtask

  task automatic test_modes();
    send(32'h40200000, CE, 32'h40400000);
    send(32'h40200000, FL, 32'h40000000);
    send(32'h40600000, TR, 32'h40400000);
    send(32'hC0200000, TR, 32'hC0000000);
    send(32'hBF000000, CE, 32'h80000000);
    send(32'hBF000000, FL, 32'hBF800000);
    send(32'h3F7FFFFF, TR, 32'h00000000);
    send(32'h3FC00000, TR, 32'h3F800000);
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] ba [6];
    logic [1:0]  bm [6];
    logic [31:0] bz [6];
    logic [31:0] held;
    int          i, n0, left;
    bit          started;
    ba = '{32'h3FC00000, 32'hBFC00000, 32'h40200000, 32'h40600000, 32'hBF333333, 32'h3E99999A};
    bm = '{CE, FL, NE, NE, TR, CE};
    bz = '{32'h40000000, 32'hC0000000, 32'h40000000, 32'h40800000, 32'h80000000, 32'h3F800000};
    lat_chk = 1'b0; n0 = n_out; i = 0; left = 0; started = 1'b0; held = '0;
    for (int t = 0; t < 80 && (i < 6 || sb.size() != 0); t++) begin
      if (i < 6) begin
        in_valid = 1'b1; in_a = ba[i]; in_mode = bm[i]; pend_z = bz[i];
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (acc_flag) i++;
      if (left > 0) begin
        checks++;
        if (smp_in_ready !== 1'b0 || smp_out_valid !== 1'b1) begin
          errors++;
          $display("FAIL stall_hold got in_ready=%b out_valid=%b required 0 1", smp_in_ready, smp_out_valid);
        end
        if (left == 5) held = smp_out_z;
        else begin
          checks++;
          if (smp_out_z !== held) begin
            errors++;
            $display("FAIL stall_data got %h required %h", smp_out_z, held);
          end
        end
        left--;
        if (left == 0) out_ready = 1'b1;
      end else if (!started && (n_out - n0) >= 1) begin
        started = 1'b1; out_ready = 1'b0; left = 5;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (n_out - n0 != 6 || !started) begin
      errors++;
      $display("FAIL bp_count got %0d results stalled=%b required 6 1", n_out - n0, started);
    end
    lat_chk = 1'b1;
  endtask

  task automatic test_reset_mid();
    drain();
    out_ready = 1'b0; lat_chk = 1'b0;
    send(32'h3FC00000, CE, 32'h40000000);
    send(32'h40600000, NE, 32'h40800000);
    send(32'hBFC00000, FL, 32'hC0000000);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    step();
    checks++;
    if (smp_out_valid !== 1'b0 || smp_out_z !== 32'h0) begin
      errors++;
      $display("FAIL midreset_out got valid=%b z=%h required 0 00000000", smp_out_valid, smp_out_z);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (smp_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_ghost got out_valid=%b z=%h required 0", smp_out_valid, smp_out_z);
      end
    end
    lat_chk = 1'b1;
    send(32'h40200000, CE, 32'h40400000);
    drain();
    for (int k = 0; k < 4; k++) step();
  endtask

  task automatic test_params();
    int          dl, hl;
    logic [63:0] dz;
    logic [15:0] hz;
    logic        di, hi;
    d_valid = 1'b1; d_a = 64'hC004000000000000; d_mode = FL;
    h_valid = 1'b1; h_a = 16'h3E00; h_mode = NE;
    step();
    checks++;
    if (smp_d_rdy !== 1'b1 || smp_h_rdy !== 1'b1) begin
      errors++;
      $display("FAIL param_ready got d=%b h=%b required 1 1", smp_d_rdy, smp_h_rdy);
    end
    d_valid = 1'b0; h_valid = 1'b0;
    dl = -1; hl = -1; dz = '0; hz = '0; di = 1'b0; hi = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (smp_d_vld === 1'b1 && dl < 0) begin dl = t; dz = smp_d_z; di = smp_d_inex; end
      if (smp_h_vld === 1'b1 && hl < 0) begin hl = t; hz = smp_h_z; hi = smp_h_inex; end
    end
    checks++;
    if (dl != 3 || dz !== 64'hC008000000000000) begin
      errors++;
      $display("FAIL double_floor got %h at +%0d required C008000000000000 at +3", dz, dl);
    end
    checks++;
    if (hl != 3 || hz !== 16'h4000) begin
      errors++;
      $display("FAIL half_nearest got %h at +%0d required 4000 at +3", hz, hl);
    end
`ifdef FP_ROUND_FLAGS_EN
    checks++;
    if (di !== 1'b1 || hi !== 1'b1) begin
      errors++;
      $display("FAIL param_inexact got d=%b h=%b required 1 1", di, hi);
    end
`endif
    h_valid = 1'b1; h_a = 16'h4000; h_mode = NE;
    step();
    h_valid = 1'b0;
    hl = -1; hz = '0; hi = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      step();
      if (smp_h_vld === 1'b1 && hl < 0) begin hl = t; hz = smp_h_z; hi = smp_h_inex; end
    end
    checks++;
    if (hl != 3 || hz !== 16'h4000) begin
      errors++;
      $display("FAIL half_integral got %h at +%0d required 4000 at +3", hz, hl);
    end
`ifdef FP_ROUND_FLAGS_EN
    checks++;
    if (hi !== 1'b0) begin
      errors++;
      $display("FAIL half_exact_flag got inexact=%b required 0", hi);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties_carry();
    test_specials();
    test_modes();
    test_backpressure();
    drain();
    test_reset_mid();
    test_params();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
